// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the requesters, the write arbiter and the register file write port.
// master = requester/register-file side, slave = arbiter.
interface regfile_write_arbiter_if #(
   parameter int WORD_LENGTH = 32,
   parameter int NBITS       = $clog2(WORD_LENGTH),
   parameter int NUM_REQ     = 4
);
   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ*NBITS-1:0]       req_reg;
   logic [NUM_REQ*WORD_LENGTH-1:0] req_data;
   logic [NUM_REQ-1:0]             ack;
   logic                           Write;
   logic [NBITS-1:0]               Write_Reg;
   logic [WORD_LENGTH-1:0]         Write_Data;
   logic [15:0]                    contention_cnt;

   modport master (
      output req, req_reg, req_data,
      input  ack, Write, Write_Reg, Write_Data, contention_cnt
   );

   modport slave (
      input  req, req_reg, req_data,
      output ack, Write, Write_Reg, Write_Data, contention_cnt
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the Register_File write port among NUM_REQ requesters.
// Optional macro REGFILE_ZERO_PROTECT_EN suppresses the Write strobe for grants targeting register 0.
module regfile_write_arbiter #(
   parameter int WORD_LENGTH = 32,
   parameter int NBITS       = $clog2(WORD_LENGTH),
   parameter int NUM_REQ     = 4,
   parameter int PTR_W       = $clog2(NUM_REQ)
) (
   input logic                   clk,
   input logic                   reset,
   regfile_write_arbiter_if.slave bus
);

   logic [PTR_W-1:0]       ptr;
   logic [NUM_REQ-1:0]     eligible;
   logic [NUM_REQ-1:0]     ack_next;
   logic                   grant;
   logic                   contended;
   logic [PTR_W-1:0]       winner;
   logic [NBITS-1:0]       sel_reg;
   logic [WORD_LENGTH-1:0] sel_data;

   // A requester that is being acknowledged this cycle is masked so a held request writes once.
   assign eligible  = bus.req & ~bus.ack;
   assign contended = $countones(eligible) >= 2;

   always_comb begin
      int idx_int;
      logic [PTR_W-1:0] idx;
      grant    = 1'b0;
      winner   = '0;
      ack_next = '0;
      idx_int  = 0;
      idx      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_int = (int'(ptr) + k) % NUM_REQ;
         idx     = idx_int[PTR_W-1:0];
         if (!grant && eligible[idx]) begin
            grant  = 1'b1;
            winner = idx;
         end
      end
      ack_next[winner] = grant;
      sel_reg  = bus.req_reg[winner*NBITS +: NBITS];
      sel_data = bus.req_data[winner*WORD_LENGTH +: WORD_LENGTH];
   end

   // ptr starts at the last index so requester 0 holds first priority out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr                <= PTR_W'(NUM_REQ - 1);
         bus.ack            <= '0;
         bus.Write          <= 1'b0;
         bus.Write_Reg      <= '0;
         bus.Write_Data     <= '0;
         bus.contention_cnt <= '0;
      end else begin
         bus.ack <= ack_next;
         if (grant) begin
            ptr            <= winner;
            bus.Write_Reg  <= sel_reg;
            bus.Write_Data <= sel_data;
         end
`ifdef REGFILE_ZERO_PROTECT_EN
         bus.Write <= grant && (sel_reg != '0);
`else
         bus.Write <= grant;
`endif
         if (contended && (bus.contention_cnt != 16'hFFFF)) begin
            bus.contention_cnt <= bus.contention_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a queue-based reference model.
// Includes a stand-in register file driven by the DUT write port.
module tb_regfile_write_arbiter;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int NB = 5;
`ifdef REGFILE_ZERO_PROTECT_EN
   localparam bit ZP = 1'b1;
`else
   localparam bit ZP = 1'b0;
`endif

   typedef struct {
      logic [NB-1:0] r;
      logic [W-1:0]  d;
   } wr_t;

   logic clk;
   logic reset;
   logic init_done;

   regfile_write_arbiter_if #(.WORD_LENGTH(W), .NUM_REQ(N)) bus();

   regfile_write_arbiter #(.WORD_LENGTH(W), .NUM_REQ(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Stand-in Register_File: commits whatever the arbiter presents on the next edge.
   logic [W-1:0] tb_regs [32];
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 32; i++) tb_regs[i] <= '0;
      end else if (bus.Write === 1'b1) begin
         tb_regs[bus.Write_Reg] <= bus.Write_Data;
      end
   end

   int checks;
   int errors;
   wr_t reqq [N][$];
   int dlog [$];

   logic [N-1:0]  m_ack;
   logic          m_write;
   logic [NB-1:0] m_wreg;
   logic [W-1:0]  m_wdata;
   logic [15:0]   m_cnt;
   int            m_last;
   logic [W-1:0]  m_regs [32];

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("[TB] %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Eligible requester closest after the last winner, walking upward with wrap.
   function automatic int pick(input logic [N-1:0] elig, input int last);
      int best;
      int bestd;
      int d;
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
         d = (i - last - 1 + 2 * N) % N;
         if (elig[i] && d < bestd) begin
            best  = i;
            bestd = d;
         end
      end
      return best;
   endfunction

   task automatic model_reset();
      m_ack   = '0;
      m_write = 1'b0;
      m_wreg  = '0;
      m_wdata = '0;
      m_cnt   = '0;
      m_last  = N - 1;
   endtask

   task automatic model_edge();
      logic [N-1:0] elig;
      int w;
      elig = bus.req & ~m_ack;
      if ($countones(elig) >= 2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_write) m_regs[m_wreg] = m_wdata;
      w = pick(elig, m_last);
      m_ack   = '0;
      m_write = 1'b0;
      if (w >= 0) begin
         m_ack[w] = 1'b1;
         m_last   = w;
         m_wreg   = bus.req_reg[w*NB +: NB];
         m_wdata  = bus.req_data[w*W +: W];
         m_write  = !(ZP && m_wreg == '0);
      end
   endtask

   task automatic apply_stimulus();
      for (int i = 0; i < N; i++) begin
         if (reqq[i].size() > 0) begin
            bus.req[i]             = 1'b1;
            bus.req_reg[i*NB +: NB] = reqq[i][0].r;
            bus.req_data[i*W +: W]  = reqq[i][0].d;
         end else begin
            bus.req[i] = 1'b0;
         end
      end
   endtask

   task automatic step(input bit pop);
      apply_stimulus();
      model_edge();
      @(posedge clk);
      #1;
      check_output("ack", 64'(bus.ack), 64'(m_ack));
      check_output("Write", 64'(bus.Write), 64'(m_write));
      if (m_write) begin
         check_output("Write_Reg", 64'(bus.Write_Reg), 64'(m_wreg));
         check_output("Write_Data", 64'(bus.Write_Data), 64'(m_wdata));
      end
      check_output("contention_cnt", 64'(bus.contention_cnt), 64'(m_cnt));
      for (int i = 0; i < N; i++) if (bus.ack[i] === 1'b1) dlog.push_back(i);
      if (pop) begin
         for (int i = 0; i < N; i++) if (m_ack[i] && reqq[i].size() > 0) void'(reqq[i].pop_front());
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      for (int i = 0; i < N; i++) reqq[i].delete();
      bus.req = '0;
      dlog.delete();
      #1;
      model_reset();
      #1;
      reset = 1'b1;
   endtask

   function automatic wr_t mk(input int r, input logic [W-1:0] d);
      wr_t x;
      x.r = NB'(r);
      x.d = d;
      return x;
   endfunction

   initial begin
      clk       = 1'b0;
      reset     = 1'b0;
      init_done = 1'b0;
      checks    = 0;
      errors    = 0;
      bus.req      = '0;
      bus.req_reg  = '0;
      bus.req_data = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      model_reset();

      @(posedge clk);
      #1;
      check_output("reset_ack", 64'(bus.ack), 64'h0);
      check_output("reset_Write", 64'(bus.Write), 64'h0);
      check_output("reset_Write_Reg", 64'(bus.Write_Reg), 64'h0);
      check_output("reset_Write_Data", 64'(bus.Write_Data), 64'h0);
      check_output("reset_cnt", 64'(bus.contention_cnt), 64'h0);
      init_done = 1'b1;
      reset     = 1'b1;

      $display("[TB] single request");
      reqq[0].push_back(mk(5, 32'hFEFEFEFE));
      step(1);
      step(1);
      step(1);
      check_output("single_reg5", 64'(tb_regs[5]), 64'hFEFEFEFE);
      check_output("single_cnt", 64'(bus.contention_cnt), 64'h0);

      $display("[TB] four requesters");
      do_reset();
      reqq[0].push_back(mk(1, 32'h11111111));
      reqq[1].push_back(mk(2, 32'h22222222));
      reqq[2].push_back(mk(3, 32'h33333333));
      reqq[3].push_back(mk(4, 32'h44444444));
      repeat (6) step(1);
      check_output("four_order_len", 64'(dlog.size()), 64'd4);
      for (int k = 0; k < 4 && k < dlog.size(); k++) check_output("four_order", 64'(dlog[k]), 64'(k));
      check_output("four_reg1", 64'(tb_regs[1]), 64'h11111111);
      check_output("four_reg2", 64'(tb_regs[2]), 64'h22222222);
      check_output("four_reg3", 64'(tb_regs[3]), 64'h33333333);
      check_output("four_reg4", 64'(tb_regs[4]), 64'h44444444);
      check_output("four_cnt", 64'(bus.contention_cnt), 64'd3);

      $display("[TB] fairness");
      do_reset();
      for (int k = 0; k < 4; k++) begin
         reqq[0].push_back(mk(8 + k, $urandom));
         reqq[2].push_back(mk(12 + k, $urandom));
      end
      repeat (9) step(1);
      check_output("fair_len", 64'(dlog.size()), 64'd8);
      for (int k = 0; k < 8 && k < dlog.size(); k++) check_output("fair_order", 64'(dlog[k]), 64'((k % 2) * 2));

      $display("[TB] collision");
      do_reset();
      reqq[1].push_back(mk(4, 32'hABABABAB));
      reqq[3].push_back(mk(4, 32'hCECECECE));
      repeat (3) step(1);
      check_output("coll_first", 64'((dlog.size() > 0) ? dlog[0] : -1), 64'd1);
      check_output("coll_second", 64'((dlog.size() > 1) ? dlog[1] : -1), 64'd3);
      check_output("coll_reg4", 64'(tb_regs[4]), 64'hCECECECE);

      $display("[TB] reset mid-operation");
      do_reset();
      reqq[1].push_back(mk(20, 32'h99999999));
      step(0);
      reset = 1'b0;
      #1;
      model_reset();
      check_output("midrst_ack", 64'(bus.ack), 64'h0);
      check_output("midrst_Write", 64'(bus.Write), 64'h0);
      @(posedge clk);
      #1;
      check_output("midrst_reg20", 64'(tb_regs[20]), 64'h0);
      reset = 1'b1;
      dlog.delete();
      reqq[0].push_back(mk(21, 32'h12345678));
      reqq[2].push_back(mk(22, 32'h87654321));
      repeat (5) step(1);
      check_output("midrst_first", 64'((dlog.size() > 0) ? dlog[0] : -1), 64'd0);
      check_output("midrst_reg20_final", 64'(tb_regs[20]), 64'h99999999);

      $display("[TB] register zero");
      do_reset();
      reqq[2].push_back(mk(0, 32'hDEADBEEF));
      repeat (2) step(1);
      check_output("zero_ack", 64'((dlog.size() > 0) ? dlog[0] : -1), 64'd2);
      check_output("zero_reg0", 64'(tb_regs[0]), ZP ? 64'h0 : 64'hDEADBEEF);

      $display("[TB] random traffic");
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (reqq[i].size() == 0 && $urandom_range(0, 2) == 0)
               reqq[i].push_back(mk($urandom_range(0, 31), $urandom));
         end
         step(1);
      end
      for (int c = 0; c < 20; c++) step(1);
      for (int r = 0; r < 32; r++) check_output("rand_reg", 64'(tb_regs[r]), 64'(m_regs[r]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
